regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Architectural integer register file: 32 x 32-bit, x0 hard-wired to zero.
- Sits behind the decode stage and answers its two read requests (address plus read-enable in, data out).
- Takes the write-back stream from the WB stage.
- Holds a per-register pending-write scoreboard so decode can detect RAW hazards and stall.

Parameters:
- REG_NUM, 32, number of architectural registers (index 0 is constant zero).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- CNT_W, 2, width of each per-register pending-writer counter (max 2^CNT_W-1 in flight).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  write-back enable from WB.
- waddr_i  in  ADDR_W  write-back destination.
- wdata_i  in  DATA_W  write-back data.
- reg1_read_i  in  1  read enable, port 1.
- reg1_addr_i  in  ADDR_W  read address, port 1.
- reg1_data_o  out  DATA_W  read data, port 1.
- reg1_busy_o  out  1  port-1 register has an uncommitted producer.
- reg2_read_i  in  1  read enable, port 2.
- reg2_addr_i  in  ADDR_W  read address, port 2.
- reg2_data_o  out  DATA_W  read data, port 2.
- reg2_busy_o  out  1  port-2 register has an uncommitted producer.
- issue_i  in  1  decode issued an instruction that writes issue_addr_i.
- issue_addr_i  in  ADDR_W  destination of the issued instruction.
- flush_i  in  1  clear all pending counters (pipeline flush).
- sb_err_o  out  1  sticky error: counter overflow or underflow attempted.

Behaviour:
- Clocking/reset: single clock domain on clk. rst is synchronous and active-high. On a clk edge with rst=1: all registers := 0, all counters := 0, sb_err_o := 0.
- Reads are combinational, zero latency, same cycle as address. Priority per port:
  - rst=1 -> data 0, busy 0.
  - read enable=0 -> data 0, busy 0.
  - addr=0 -> data 0, busy 0.
  - bypass hit (see Optional Feature) -> wdata_i.
  - otherwise regs[addr].
- Busy per port: cnt[addr]!=0, modified by bypass rules below.
- Write, at clk edge with rst=0: if we_i and waddr_i!=0 then regs[waddr_i] := wdata_i. Writes to x0 are discarded.
- Counter update, at clk edge with rst=0, for each register r!=0:
  - inc = issue_i && issue_addr_i==r.
  - dec = we_i && waddr_i==r.
  - inc only: cnt+1. If cnt is at max, hold and set sb_err_o.
  - dec only: cnt-1. If cnt=0, hold at 0 and set sb_err_o.
  - inc and dec together: cnt unchanged.
  - Address 0 never counts.
- flush_i: all counters := 0 at the edge, overriding inc/dec in that cycle. A register write still occurs. A later write-back to a zero counter after a flush does NOT set sb_err_o; this exemption lasts until the next issue to that register. Track it with one "flushed" bit per register: set by flush_i, cleared by an issue to that register.
- sb_err_o is sticky until rst.
- Both ports may read the same address; results must be identical.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Read with we_i=1, waddr_i==addr, addr!=0 returns wdata_i.
  - Busy is 0 if cnt[addr]==1 and no same-cycle issue to addr.
- Undefined:
  - Reads return the stored regs[addr] (old value).
  - Busy = cnt[addr]!=0 regardless of the same-cycle write-back. Decode stalls one extra cycle.

Test Plan:
- Reset then read: rst=1 one cycle; read x5 both ports -> data 0, busy 0, sb_err_o 0.
- Write/read: we_i=1, waddr_i=3, wdata_i=0xDEADBEEF; next cycle read x3 -> 0xDEADBEEF. Write 0x1234 to x0 -> read x0 returns 0.
- Bypass (REGFILE_BYPASS_EN defined): x7=0x11; same cycle we_i=1, waddr_i=7, wdata_i=0x22 and read x7 -> 0x22. With the macro undefined -> 0x11.
- Scoreboard: issue x9 three times -> reg1_busy_o=1 for x9. Three write-backs to x9 -> busy drops after the third (same cycle if bypass enabled, next cycle otherwise). Fourth issue at count 3 sets sb_err_o=1.
- Simultaneous issue+wb to x4 with cnt=1 -> cnt stays 1 and busy stays 1. Write-back to x4 with cnt=0 and no prior flush -> sb_err_o=1.
- Flush: issue x6 twice, flush_i=1 -> busy 0 next cycle. Two subsequent write-backs to x6 -> register updated, sb_err_o stays 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file (x0 = 0) with per-register pending-writer scoreboard for RAW stall detection.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data and busy release to the read ports.
module regfile_sb #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              reg1_read_i,
    input  logic [ADDR_W-1:0] reg1_addr_i,
    output logic [DATA_W-1:0] reg1_data_o,
    output logic              reg1_busy_o,
    input  logic              reg2_read_i,
    input  logic [ADDR_W-1:0] reg2_addr_i,
    output logic [DATA_W-1:0] reg2_data_o,
    output logic              reg2_busy_o,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              flush_i,
    output logic              sb_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] regs      [REG_NUM];
    logic [CNT_W-1:0]  cnt       [REG_NUM];
    logic [CNT_W-1:0]  cnt_next  [REG_NUM];
    logic [REG_NUM-1:0] flushed;
    logic [REG_NUM-1:0] flushed_next;
    logic              sb_err;
    logic              err_set;

    // Next counter values; "flushed" exempts the first write-backs after a flush from underflow errors.
    always_comb begin
        err_set      = 1'b0;
        flushed_next = flushed;
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_next[r] = cnt[r];
        end
        cnt_next[0]     = '0;
        flushed_next[0] = 1'b0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (flush_i) begin
                cnt_next[r]     = '0;
                flushed_next[r] = 1'b1;
            end else begin
                if (issue_i && issue_addr_i == ADDR_W'(r)) begin
                    flushed_next[r] = 1'b0;
                end
                if ((issue_i && issue_addr_i == ADDR_W'(r)) && !(we_i && waddr_i == ADDR_W'(r))) begin
                    if (cnt[r] == CNT_MAX) begin
                        err_set = 1'b1;
                    end else begin
                        cnt_next[r] = cnt[r] + CNT_W'(1);
                    end
                end else if ((we_i && waddr_i == ADDR_W'(r)) && !(issue_i && issue_addr_i == ADDR_W'(r))) begin
                    if (cnt[r] == '0) begin
                        if (!flushed[r]) begin
                            err_set = 1'b1;
                        end
                    end else begin
                        cnt_next[r] = cnt[r] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            flushed <= '0;
            sb_err  <= 1'b0;
        end else begin
            if (we_i && waddr_i != '0) begin
                regs[waddr_i] <= wdata_i;
            end
            for (int r = 0; r < REG_NUM; r++) begin
                cnt[r] <= cnt_next[r];
            end
            flushed <= flushed_next;
            sb_err  <= sb_err | err_set;
        end
    end

    // Returns {busy, data} for one read port.
    function automatic logic [DATA_W:0] read_port(
        input logic              rd,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic [CNT_W-1:0]  c
    );
        logic [DATA_W-1:0] data;
        logic              busy;
        data = '0;
        busy = 1'b0;
        if (!rst && rd && a != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (we_i && waddr_i == a) begin
                data = wdata_i;
                busy = (c != '0) && !(c == CNT_W'(1) && !(issue_i && issue_addr_i == a));
            end else begin
                data = stored;
                busy = (c != '0);
            end
`else
            data = stored;
            busy = (c != '0);
`endif
        end
        return {busy, data};
    endfunction

    always_comb begin
        {reg1_busy_o, reg1_data_o} = read_port(reg1_read_i, reg1_addr_i, regs[reg1_addr_i], cnt[reg1_addr_i]);
        {reg2_busy_o, reg2_data_o} = read_port(reg2_read_i, reg2_addr_i, regs[reg2_addr_i], cnt[reg2_addr_i]);
    end

    assign sb_err_o = sb_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        reg1_read_i;
    logic [4:0]  reg1_addr_i;
    logic [31:0] reg1_data_o;
    logic        reg1_busy_o;
    logic        reg2_read_i;
    logic [4:0]  reg2_addr_i;
    logic [31:0] reg2_data_o;
    logic        reg2_busy_o;
    logic        issue_i;
    logic [4:0]  issue_addr_i;
    logic        flush_i;
    logic        sb_err_o;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_sb dut (
        .clk          (clk),
        .rst          (rst),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .reg1_read_i  (reg1_read_i),
        .reg1_addr_i  (reg1_addr_i),
        .reg1_data_o  (reg1_data_o),
        .reg1_busy_o  (reg1_busy_o),
        .reg2_read_i  (reg2_read_i),
        .reg2_addr_i  (reg2_addr_i),
        .reg2_data_o  (reg2_data_o),
        .reg2_busy_o  (reg2_busy_o),
        .issue_i      (issue_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .sb_err_o     (sb_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.name, "reg1_data", reg1_data_o, e.d1);
        compareField(e.name, "reg1_busy", 32'(reg1_busy_o), 32'(e.b1));
        compareField(e.name, "reg2_data", reg2_data_o, e.d2);
        compareField(e.name, "reg2_busy", 32'(reg2_busy_o), 32'(e.b2));
        compareField(e.name, "sb_err", 32'(sb_err_o), 32'(e.err));
    endtask

    // Drives one cycle of inputs and queues the outputs expected while they are applied.
    task automatic applyStimulus(
        input string name, input logic r,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic rd1, input logic [4:0] a1, input logic rd2, input logic [4:0] a2,
        input logic iss, input logic [4:0] ia, input logic fl,
        input logic [31:0] ed1, input logic eb1, input logic [31:0] ed2, input logic eb2, input logic eerr
    );
        exp_t e;
        rst = r; we_i = we; waddr_i = wa; wdata_i = wd;
        reg1_read_i = rd1; reg1_addr_i = a1; reg2_read_i = rd2; reg2_addr_i = a2;
        issue_i = iss; issue_addr_i = ia; flush_i = fl;
        e.name = name; e.d1 = ed1; e.b1 = eb1; e.d2 = ed2; e.b2 = eb2; e.err = eerr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        reg1_read_i = 1'b0; reg1_addr_i = '0; reg2_read_i = 1'b0; reg2_addr_i = '0;
        issue_i = 1'b0; issue_addr_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus("reset_read", 1, 0, 0, 0, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("issue_x3", 0, 0, 0, 0, 1, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        applyStimulus("write_x3", 0, 1, 3, 32'hDEADBEEF, 1, 3, 1, 3, 0, 0, 0,
                      BYP ? 32'hDEADBEEF : 32'h0, !BYP, BYP ? 32'hDEADBEEF : 32'h0, !BYP, 0);
        applyStimulus("write_x0", 0, 1, 0, 32'h1234, 1, 3, 1, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        applyStimulus("read_x0_disabled", 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("issue_x7", 0, 0, 0, 0, 1, 7, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        applyStimulus("wb_issue_x7", 0, 1, 7, 32'h11, 1, 7, 1, 7, 1, 7, 0,
                      BYP ? 32'h11 : 32'h0, 1, BYP ? 32'h11 : 32'h0, 1, 0);
        applyStimulus("bypass_x7", 0, 1, 7, 32'h22, 1, 7, 1, 7, 0, 0, 0,
                      BYP ? 32'h22 : 32'h11, !BYP, BYP ? 32'h22 : 32'h11, !BYP, 0);
        applyStimulus("read_x7", 0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0, 32'h22, 0, 32'h22, 0, 0);
        applyStimulus("issue_x9_a", 0, 0, 0, 0, 1, 9, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        applyStimulus("issue_x9_b", 0, 0, 0, 0, 1, 9, 0, 0, 1, 9, 0, 0, 1, 0, 0, 0);
        applyStimulus("issue_x9_c", 0, 0, 0, 0, 1, 9, 0, 0, 1, 9, 0, 0, 1, 0, 0, 0);
        applyStimulus("wb_x9_a", 0, 1, 9, 32'hA1, 1, 9, 0, 0, 0, 0, 0, BYP ? 32'hA1 : 32'h0, 1, 0, 0, 0);
        applyStimulus("wb_x9_b", 0, 1, 9, 32'hA2, 1, 9, 0, 0, 0, 0, 0, BYP ? 32'hA2 : 32'hA1, 1, 0, 0, 0);
        applyStimulus("wb_x9_c", 0, 1, 9, 32'hA3, 1, 9, 0, 0, 0, 0, 0, BYP ? 32'hA3 : 32'hA2, !BYP, 0, 0, 0);
        applyStimulus("drained_x9", 0, 0, 0, 0, 1, 9, 1, 4, 1, 4, 0, 32'hA3, 0, 0, 0, 0);
        applyStimulus("wb_issue_x4", 0, 1, 4, 32'h44, 1, 4, 0, 0, 1, 4, 0, BYP ? 32'h44 : 32'h0, 1, 0, 0, 0);
        applyStimulus("hold_x4", 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 32'h44, 1, 0, 0, 0);
        applyStimulus("issue_x6_a", 0, 0, 0, 0, 1, 6, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0);
        applyStimulus("issue_x6_b", 0, 0, 0, 0, 1, 6, 0, 0, 1, 6, 0, 0, 1, 0, 0, 0);
        applyStimulus("flush", 0, 0, 0, 0, 1, 6, 1, 4, 0, 0, 1, 0, 1, 32'h44, 1, 0);
        applyStimulus("wb_x6_a", 0, 1, 6, 32'h66, 1, 6, 1, 4, 0, 0, 0, BYP ? 32'h66 : 32'h0, 0, 32'h44, 0, 0);
        applyStimulus("wb_x6_b", 0, 1, 6, 32'h67, 1, 6, 0, 0, 0, 0, 0, BYP ? 32'h67 : 32'h66, 0, 0, 0, 0);
        applyStimulus("wb_x4_flushed", 0, 1, 4, 32'h45, 1, 6, 1, 4, 0, 0, 0, 32'h67, 0, BYP ? 32'h45 : 32'h44, 0, 0);
        applyStimulus("issue_x4", 0, 0, 0, 0, 0, 0, 1, 4, 1, 4, 0, 0, 0, 32'h45, 0, 0);
        applyStimulus("wb_x4_legal", 0, 1, 4, 32'h46, 1, 4, 0, 0, 0, 0, 0, BYP ? 32'h46 : 32'h45, !BYP, 0, 0, 0);
        applyStimulus("wb_x4_underflow", 0, 1, 4, 32'h47, 1, 4, 0, 0, 0, 0, 0, BYP ? 32'h47 : 32'h46, 0, 0, 0, 0);
        applyStimulus("err_set", 0, 0, 0, 0, 1, 4, 1, 4, 0, 0, 0, 32'h47, 0, 32'h47, 0, 1);
        applyStimulus("reset_again", 1, 0, 0, 0, 1, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("after_reset", 0, 0, 0, 0, 1, 4, 1, 9, 1, 9, 0, 0, 0, 0, 0, 0);
        applyStimulus("issue_x9_d", 0, 0, 0, 0, 1, 9, 1, 9, 1, 9, 0, 0, 1, 0, 1, 0);
        applyStimulus("issue_x9_e", 0, 0, 0, 0, 1, 9, 1, 9, 1, 9, 0, 0, 1, 0, 1, 0);
        applyStimulus("issue_x9_overflow", 0, 0, 0, 0, 1, 9, 1, 9, 1, 9, 0, 0, 1, 0, 1, 0);
        applyStimulus("overflow_seen", 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 0, 0, 1, 0, 1, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
